// File: rtl/adc_req_arbiter_if.sv
// Request/response bundle between three ADC requesters (master) and the arbiter (slave).
// Level-sensitive requests; responses are single-cycle one-hot pulses with held data.
interface adc_req_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  req_ch0;
  logic [2:0]  req_ch1;
  logic [2:0]  req_ch2;
  logic [2:0]  rsp_valid;
  logic [11:0] rsp_data;
  logic [2:0]  rsp_ch;
  logic        busy;

  modport master (
    output req, req_ch0, req_ch1, req_ch2,
    input  rsp_valid, rsp_data, rsp_ch, busy
  );

  modport slave (
    input  req, req_ch0, req_ch1, req_ch2,
    output rsp_valid, rsp_data, rsp_ch, busy
  );
endinterface

// File: rtl/adc_req_arbiter.sv
// Round-robin arbiter sharing one ADC128S022 among three requesters; req->rsp_valid is 33*SCK_HALF+1 cycles.
// No backpressure: requests arriving while busy simply wait for the next IDLE cycle.
module adc_req_arbiter #(
  parameter int unsigned SCK_HALF = 10
) (
  input  logic             clk_50,
  input  logic             rst_n,
  adc_req_arbiter_if.slave rq,
  output logic             adc_cs_n,
  output logic             adc_sck,
  output logic             din,
  input  logic             dout
);

  localparam logic [8:0] HALF_LAST  = 9'(SCK_HALF - 1);
  // DONE itself is the first of the 2*SCK_HALF chip-select-high cycles.
  localparam logic [8:0] QUIET_LAST = 9'(2 * SCK_HALF - 2);

  typedef enum logic [1:0] {IDLE, FRAME, DONE, QUIET} state_t;

  state_t      state, state_nxt;
  logic [8:0]  cnt;
  logic [5:0]  edges;
  logic [1:0]  ptr;
  logic [1:0]  owner;
  logic [2:0]  ch;
  logic [11:0] shreg;
  logic [1:0]  win;
  logic [2:0]  win_ch;
  logic        grant;
  logic        half_end;
  logic        frame_end;
  logic        quiet_end;
  logic        sample;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
    logic b;
    case (i)
      2'd0:    b = r[0];
      2'd1:    b = r[1];
      default: b = r[2];
    endcase
    return b;
  endfunction

  always_comb begin
    win    = inc3(inc3(ptr));
    win_ch = rq.req_ch2;
    if (req_at(rq.req, ptr))
      win = ptr;
    else if (req_at(rq.req, inc3(ptr)))
      win = inc3(ptr);
    case (win)
      2'd0:    win_ch = rq.req_ch0;
      2'd1:    win_ch = rq.req_ch1;
      default: win_ch = rq.req_ch2;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    half_end  = (cnt == HALF_LAST);
    frame_end = half_end && (edges == 6'd32);
    quiet_end = (cnt == QUIET_LAST);
    // dout is valid in the first cycle after each rising sck edge of cycles 5..16
    sample    = (state == FRAME) && (cnt == 9'd0) && !edges[0] && (edges >= 6'd10);
    case (state)
      IDLE: begin
        if (|rq.req) begin
          grant     = 1'b1;
          state_nxt = FRAME;
        end
      end
      FRAME:   if (frame_end) state_nxt = DONE;
      DONE:    state_nxt = QUIET;
      QUIET:   if (quiet_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      edges        <= '0;
      ptr          <= '0;
      owner        <= '0;
      ch           <= '0;
      shreg        <= '0;
      adc_cs_n     <= 1'b1;
      adc_sck      <= 1'b1;
      din          <= 1'b0;
      rq.rsp_valid <= '0;
      rq.rsp_data  <= '0;
      rq.rsp_ch    <= '0;
      rq.busy      <= 1'b0;
    end else begin
      rq.rsp_valid <= '0;
      if (sample)
        shreg <= {shreg[10:0], dout};
      case (state)
        IDLE: begin
          if (grant) begin
            owner    <= win;
            ptr      <= inc3(win);
            ch       <= win_ch;
            cnt      <= '0;
            edges    <= '0;
            adc_cs_n <= 1'b0;
            adc_sck  <= 1'b1;
            din      <= 1'b0;
            rq.busy  <= 1'b1;
          end
        end
        FRAME: begin
          if (frame_end) begin
            cnt          <= '0;
            adc_cs_n     <= 1'b1;
            rq.rsp_valid <= 3'b001 << owner;
            rq.rsp_data  <= shreg;
            rq.rsp_ch    <= ch;
          end else if (half_end) begin
            cnt     <= '0;
            edges   <= edges + 6'd1;
            adc_sck <= ~adc_sck;
            // even count before the toggle means this edge is falling
            if (!edges[0]) begin
              case (edges)
                6'd4:    din <= ch[2];
                6'd6:    din <= ch[1];
                6'd8:    din <= ch[0];
                default: din <= 1'b0;
              endcase
            end
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        DONE: cnt <= '0;
        QUIET: begin
          cnt <= cnt + 9'd1;
          if (quiet_end)
            rq.busy <= 1'b0;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_req_arbiter.sv
// Bench for adc_req_arbiter: ADC serial responder, frame-timing reference model, directed and random stimulus.
module tb_adc_req_arbiter;
  localparam int H = 10;

  logic clk_50 = 1'b0;
  logic rst_n;
  logic adc_cs_n, adc_sck, din, dout;

  adc_req_arbiter_if rq();

  adc_req_arbiter #(.SCK_HALF(H)) dut (
    .clk_50  (clk_50),
    .rst_n   (rst_n),
    .rq      (rq),
    .adc_cs_n(adc_cs_n),
    .adc_sck (adc_sck),
    .din     (din),
    .dout    (dout)
  );

  always #5 clk_50 = ~clk_50;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference model state
  bit          m_active = 0;
  int          m_g      = 0;
  int          m_win    = 0;
  int          m_ptr    = 0;
  logic [2:0]  m_chan   = '0;
  logic [11:0] m_data   = '0;
  logic [2:0]  m_ch     = '0;
  logic [11:0] adc_q[$];

  bit          force_en  = 0;
  logic [11:0] force_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: grant when idle and any request seen at the edge; everything else follows from cycle offset.
  always @(posedge clk_50) begin
    int  tp;
    bit  found;
    tp  = cyc;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_active = 0;
      m_ptr    = 0;
      m_data   = '0;
      m_ch     = '0;
      adc_q.delete();
    end else begin
      if ((!m_active || (tp - m_g) >= 35 * H) && rq.req != 3'b000) begin
        found = 0;
        for (int j = 0; j < 3; j++) begin
          int idx;
          idx = (m_ptr + j) % 3;
          if (!found && rq.req[2'(idx)]) begin
            found = 1;
            m_win = idx;
          end
        end
        m_ptr = (m_win + 1) % 3;
        case (m_win)
          0:       m_chan = rq.req_ch0;
          1:       m_chan = rq.req_ch1;
          default: m_chan = rq.req_ch2;
        endcase
        m_g      = cyc;
        m_active = 1;
      end
      if (m_active && cyc == m_g + 33 * H) begin
        m_ch = m_chan;
        if (adc_q.size() > 0) m_data = adc_q.pop_front();
        else                  m_data = 'x;
      end
    end
  end

  always @(negedge clk_50) begin
    logic [3:0]  ctl_e;
    logic [17:0] rsp_e;
    int d, e, k;
    ctl_e = 4'b1100;
    rsp_e = '0;
    if (rst_n) begin
      rsp_e = {3'b000, m_data, m_ch};
      if (m_active && (cyc - m_g) < 35 * H) begin
        d = cyc - m_g;
        e = d / H;
        k = (e + 1) / 2;
        ctl_e[3] = (d >= 33 * H);
        ctl_e[2] = !(d < 33 * H && (e % 2) == 1);
        ctl_e[1] = (k == 3) ? m_chan[2] : (k == 4) ? m_chan[1] : (k == 5) ? m_chan[0] : 1'b0;
        ctl_e[0] = 1'b1;
        if (d == 33 * H) rsp_e[17:15] = 3'b001 << m_win;
      end
    end
    check("ctl{cs_n,sck,din,busy}", 32'({adc_cs_n, adc_sck, din, rq.busy}), 32'(ctl_e));
    check("rsp{valid,data,ch}", 32'({rq.rsp_valid, rq.rsp_data, rq.rsp_ch}), 32'(rsp_e));
  end

  // ADC responder: new random word per frame, MSB shifted out on falling edge of sck cycle 5.
  initial begin
    bit          pcs, psck;
    int          kf;
    logic [11:0] sh;
    pcs = 1; psck = 1; kf = 0; sh = '0; dout = 1'b0;
    forever begin
      @(posedge clk_50);
      #1;
      if (pcs && !adc_cs_n) begin
        kf = 0;
        sh = force_en ? force_val : 12'($urandom_range(0, 4095));
        adc_q.push_back(sh);
      end
      if (!adc_cs_n && psck && !adc_sck) begin
        kf++;
        if (kf >= 5 && kf <= 16) begin
          dout = sh[11];
          sh   = {sh[10:0], 1'b0};
        end else begin
          dout = 1'($urandom_range(0, 1));
        end
      end
      pcs  = adc_cs_n;
      psck = adc_sck;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #2;
  endtask

  task automatic wait_grant(output int g);
    bit ok;
    ok = 0;
    g  = cyc;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk_50);
      if (adc_cs_n == 1'b0) begin
        ok = 1;
        g  = cyc;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL grant_wait: got no grant, expected one within 500 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_rsp(output int at, output logic [2:0] v, output logic [11:0] dat, output logic [2:0] c);
    bit ok;
    ok = 0; at = cyc; v = '0; dat = '0; c = '0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk_50);
      if (rq.rsp_valid != 3'b000) begin
        ok = 1; at = cyc; v = rq.rsp_valid; dat = rq.rsp_data; c = rq.rsp_ch;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL rsp_wait: got no rsp_valid, expected one within 800 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic din_at(input int g, input int k, output logic b);
    do @(negedge clk_50); while (cyc < g + (2 * k - 1) * H + 1);
    b = din;
  endtask

  initial begin
    int          g, t0, at, prev_at, r;
    logic [2:0]  v, c;
    logic [11:0] dat;
    logic        b3, b4, b5;
    logic [2:0]  exp_v[4];
    logic [2:0]  exp_c[4];

    rst_n = 1'b0;
    rq.req = '0; rq.req_ch0 = '0; rq.req_ch1 = '0; rq.req_ch2 = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    @(negedge clk_50);
    check("reset_cs_sck_din_busy", 32'({adc_cs_n, adc_sck, din, rq.busy}), 32'h0000_000c);
    check("reset_rsp", 32'({rq.rsp_valid, rq.rsp_data, rq.rsp_ch}), 32'h0);

    // single request, channel 5, ADC returns 0xA5C
    tick(1);
    force_en = 1; force_val = 12'hA5C;
    rq.req_ch0 = 3'd5; rq.req = 3'b001; t0 = cyc;
    wait_grant(g);
    check("s1_grant_latency", 32'(g - t0), 32'd1);
    din_at(g, 3, b3); din_at(g, 4, b4); din_at(g, 5, b5);
    check("s1_din_ch5", 32'({b3, b4, b5}), 32'b101);
    wait_rsp(at, v, dat, c);
    check("s1_latency", 32'(at - t0), 32'd331);
    check("s1_rsp_valid", 32'(v), 32'b001);
    check("s1_rsp_data", 32'(dat), 32'hA5C);
    check("s1_rsp_ch", 32'(c), 32'd5);
    rq.req = '0; force_en = 0;

    // all three requesting from reset
    tick(1);
    rst_n = 1'b0;
    rq.req_ch0 = 3'd5; rq.req_ch1 = 3'd6; rq.req_ch2 = 3'd7; rq.req = 3'b111;
    tick(3);
    rst_n = 1'b1; r = cyc;
    exp_v[0] = 3'b001; exp_v[1] = 3'b010; exp_v[2] = 3'b100; exp_v[3] = 3'b001;
    exp_c[0] = 3'd5;   exp_c[1] = 3'd6;   exp_c[2] = 3'd7;   exp_c[3] = 3'd5;
    prev_at = 0;
    for (int n = 0; n < 4; n++) begin
      wait_rsp(at, v, dat, c);
      if (n == 0) check("s2_first_latency", 32'(at - r), 32'd331);
      else        check("s2_spacing", 32'(at - prev_at), 32'd351);
      check("s2_order", 32'(v), 32'(exp_v[n]));
      check("s2_ch", 32'(c), 32'(exp_c[n]));
      prev_at = at;
    end
    rq.req = '0;
    tick(25);

    // channel changes mid-frame must not affect the frame
    rq.req_ch1 = 3'd6; rq.req = 3'b010;
    wait_grant(g);
    do @(negedge clk_50); while (cyc < g + 50);
    rq.req_ch1 = 3'd2;
    din_at(g, 3, b3); din_at(g, 4, b4); din_at(g, 5, b5);
    check("s3_din_ch6", 32'({b3, b4, b5}), 32'b110);
    wait_rsp(at, v, dat, c);
    check("s3_rsp_valid", 32'(v), 32'b010);
    check("s3_rsp_ch", 32'(c), 32'd6);
    rq.req = '0;
    tick(25);

    // request dropped mid-frame still completes
    rq.req_ch0 = 3'd3; rq.req = 3'b001;
    wait_grant(g);
    do @(negedge clk_50); while (cyc < g + 100);
    rq.req = '0;
    wait_rsp(at, v, dat, c);
    check("s4_rsp_valid", 32'(v), 32'b001);
    check("s4_grant_to_done", 32'(at - g), 32'd330);
    check("s4_rsp_ch", 32'(c), 32'd3);
    tick(25);

    // reset mid-frame: frame abandoned, pointer back to requester 0
    rq.req_ch0 = 3'd1; rq.req_ch1 = 3'd4; rq.req = 3'b011;
    wait_grant(g);
    do @(negedge clk_50); while (cyc < g + 149);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("s5_reset_cs_sck", 32'({adc_cs_n, adc_sck}), 32'b11);
    check("s5_reset_busy", 32'(rq.busy), 32'd0);
    tick(3);
    rst_n = 1'b1; r = cyc;
    wait_rsp(at, v, dat, c);
    check("s5_no_stale_rsp_latency", 32'(at - r), 32'd331);
    check("s5_rsp_valid", 32'(v), 32'b001);
    rq.req = '0;
    tick(25);

    // request 2 arrives during QUIET: granted only once IDLE is reached
    rq.req_ch0 = 3'd2; rq.req = 3'b001;
    wait_rsp(at, v, dat, c);
    rq.req = '0;
    t0 = at;
    do @(negedge clk_50); while (cyc < t0 + 5);
    rq.req_ch2 = 3'd7; rq.req = 3'b100;
    wait_grant(g);
    check("s6_grant_after_quiet", 32'(g - t0), 32'd21);
    wait_rsp(at, v, dat, c);
    check("s6_rsp_valid", 32'(v), 32'b100);
    check("s6_rsp_ch", 32'(c), 32'd7);
    rq.req = '0;
    tick(25);

    // random traffic
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 39) == 0) rq.req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        rq.req_ch0 = 3'($urandom_range(0, 7));
        rq.req_ch1 = 3'($urandom_range(0, 7));
        rq.req_ch2 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 6999) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      tick(1);
    end
    rq.req = '0;
    tick(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_req_arbiter.md
ADC_REQ_ARBITER -- requirements
Module: adc_req_arbiter

Interface
REQ-001 Parameter SCK_HALF, default 10, clk_50 cycles per adc_sck half-period (10 gives 2.5 MHz); legal values are 2 to 255.
REQ-002 clk_50  in  1  system clock (50 MHz); all logic is in this single domain.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req  in  3  per-requester conversion request (bit i = requester i), level-sensitive.
REQ-005 req_ch0, req_ch1, req_ch2  in  3 each  ADC channel address for requester 0/1/2.
REQ-006 rsp_valid  out  3  one-hot, single-cycle pulse; result is ready for requester i.
REQ-007 rsp_data  out  12  conversion result; valid while any rsp_valid bit is high, held otherwise.
REQ-008 rsp_ch  out  3  channel address of the result on rsp_data.
REQ-009 busy  out  1  high from grant to the end of the quiet time.
REQ-010 adc_cs_n  out  1  ADC128S022 chip select, active low.
REQ-011 adc_sck  out  1  ADC serial clock; idles high.
REQ-012 din  out  1  serial channel address to the ADC.
REQ-013 dout  in  1  serial conversion data from the ADC.

Function
REQ-014 The FSM states SHALL be IDLE, FRAME, DONE and QUIET; reset enters IDLE.
REQ-015 IDLE: when req != 0 is sampled in cycle T, the arbiter SHALL grant in T+1 (cycle G), latch the winner and its req_chN, drive adc_cs_n=0 and busy=1, and enter FRAME.
REQ-016 Arbitration SHALL be round-robin:
- search starts at pointer p (reset 0) and proceeds p, p+1, p+2 mod 3;
- after granting i, p becomes (i+1) mod 3.
REQ-017 The channel address SHALL be captured at grant; later changes to req_chN do not affect the current frame.
REQ-018 FRAME SHALL generate 16 sck cycles k=1..16:
- falling edge at G+SCK_HALF*(2k-1);
- rising edge at G+SCK_HALF*2k.
REQ-019 din SHALL be updated on each falling edge:
- cycles 3, 4, 5 carry ch[2], ch[1], ch[0];
- all other cycles carry 0.
REQ-020 dout SHALL be sampled in the clk_50 cycle in which adc_sck rises:
- cycles 5..16 give data[11] down to data[0], MSB first;
- cycles 1..4 are ignored.
REQ-021 At G+33*SCK_HALF the block SHALL enter DONE and, in that cycle:
- drive adc_cs_n=1;
- pulse rsp_valid[i] for exactly one cycle;
- present rsp_data and rsp_ch.
REQ-022 QUIET SHALL hold adc_cs_n=1 and adc_sck=1 for 2*SCK_HALF cycles, then return to IDLE and drop busy.
REQ-023 No grant SHALL occur in FRAME, DONE or QUIET; requests arriving then wait and are arbitrated on the first IDLE cycle.
REQ-024 A requester SHALL hold req high until its rsp_valid; req still high in the first IDLE cycle after QUIET counts as a new request.
REQ-025 Deasserting req mid-frame SHALL NOT abort the frame; the result is still delivered.
REQ-026 rsp_data and rsp_ch SHALL hold their last value until the next DONE.
REQ-027 With SCK_HALF=10, latency from req sampled to rsp_valid SHALL be 331 cycles, and back-to-back grants SHALL be 351 cycles apart.
REQ-028 When all three requesters are held high continuously, grants SHALL cycle 0,1,2,0,...

Reset
REQ-029 While rst_n=0, outputs SHALL immediately take these values:
- adc_cs_n=1, adc_sck=1, din=0;
- rsp_valid=0, rsp_data=0, rsp_ch=0, busy=0;
- pointer=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no rsp_valid; after release the block resumes in IDLE.
REQ-031 Reset release SHALL be treated as synchronous to clk_50; the first grant is no earlier than one cycle after release.

Verification
REQ-032 Single request: req=001, req_ch0=5, ADC model returns 0xA5C. Required: din bits 1,0,1 in cycles 3-5; rsp_valid=001 at T+331; rsp_data=0xA5C; rsp_ch=5.
REQ-033 All three requesters high from reset (channels 5, 6, 7). Required: grant order 0,1,2,0; rsp_valid spacing 351 cycles; rsp_ch sequence 5,6,7,5.
REQ-034 req_ch1 changed from 6 to 2 in cycle G+50. Required: din still carries 1,1,0; rsp_ch=6.
REQ-035 req0 dropped at G+100. Required: frame completes and rsp_valid=001 still pulses.
REQ-036 rst_n pulsed low at G+150. Required: adc_cs_n=1 and adc_sck=1 immediately; no rsp_valid; next grant goes to requester 0.
REQ-037 Requester 2 asserts during QUIET while requester 0 is idle. Required: grant on the first IDLE cycle after QUIET ends; no grant inside QUIET.
